// File: rtl/rv32_debug_pkg.sv
// Shared debug-port definitions for the RV32 debug scan sequencer and the
// core-side debug mux.
//   dbg_scan_state_t : sequencer state encoding
//   DBG_ADDR_W       : width of the core's debug_addr
//   DBG_DATA_W       : width of the core's debug_data
package rv32_debug_pkg;

  localparam int unsigned DBG_ADDR_W = 7;
  localparam int unsigned DBG_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_SET  = 3'd2,
    ST_WAIT = 3'd3,
    ST_EMIT = 3'd4
  } dbg_scan_state_t;

endpackage

// File: rtl/rv32_debug_scan_rise_edge_det.sv
// 1-bit rising-edge detector with a registered history bit.
// Ports:
//   i_clk  : clock (rising edge)
//   i_rst  : synchronous active-high reset (history cleared to 0)
//   i_d    : sampled level
//   o_rise : high while i_d is 1 and was 0 on the previous edge
module rise_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/rv32_debug_scan.sv
// Debug-port sequencer in front of the RV32 core debug interface. Turns a
// step request edge into a one-cycle debug_step pulse and, on scan_start,
// sweeps debug_addr over [ADDR_FIRST, ADDR_LAST], emitting one (addr, data)
// beat per word on a valid/ready stream.
// Optional feature macro: DEBUG_SCAN_AUTO_RESCAN_EN (every step is followed
// by a full sweep without scan_start).
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_dbg_mode         : debug mode level; dropping it while busy aborts
//   i_step_req         : raw step request (rising edge used)
//   i_scan_start       : level, starts a sweep when sampled in IDLE
//   i_debug_data       : read data from the core
//   o_debug_en         : registered copy of i_dbg_mode
//   o_debug_step       : one-cycle step pulse to the core
//   o_debug_addr       : current sweep address to the core
//   o_out_valid/i_out_ready/o_out_addr/o_out_data : beat stream
//   o_busy             : not IDLE
//   o_done             : one-cycle pulse after the last beat is accepted
module rv32_debug_scan
  import rv32_debug_pkg::*;
#(
  parameter int unsigned ADDR_W     = DBG_ADDR_W,
  parameter int unsigned DATA_W     = DBG_DATA_W,
  parameter int unsigned ADDR_FIRST = 0,
  parameter int unsigned ADDR_LAST  = 127,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dbg_mode,
  input  logic              i_step_req,
  input  logic              i_scan_start,
  input  logic [DATA_W-1:0] i_debug_data,
  output logic              o_debug_en,
  output logic              o_debug_step,
  output logic [ADDR_W-1:0] o_debug_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned       CNT_W  = 2;
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(ADDR_FIRST);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(ADDR_LAST);

  dbg_scan_state_t r_state;
  dbg_scan_state_t w_state_nxt;

  logic              w_step_rise;
  logic              r_debug_en;
  logic [ADDR_W-1:0] r_debug_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_done;

  logic w_load_first;
  logic w_inc_addr;
  logic w_load_cnt;
  logic w_dec_cnt;
  logic w_capture;
  logic w_clear_valid;
  logic w_set_done;

  rise_edge_det u_step_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_step_req),
    .o_rise (w_step_rise)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_first  = 1'b0;
    w_inc_addr    = 1'b0;
    w_load_cnt    = 1'b0;
    w_dec_cnt     = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    w_set_done    = 1'b0;
    // Losing debug mode outside IDLE aborts from any state, including a
    // pending beat, which is withdrawn without a done pulse.
    if ((r_state != ST_IDLE) && !i_dbg_mode) begin
      w_state_nxt   = ST_IDLE;
      w_clear_valid = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_dbg_mode && w_step_rise) begin
            w_state_nxt = ST_STEP;
          end else if (i_dbg_mode && i_scan_start) begin
            w_state_nxt  = ST_SET;
            w_load_first = 1'b1;
          end
        end
        ST_STEP: begin
`ifdef DEBUG_SCAN_AUTO_RESCAN_EN
          w_state_nxt  = ST_SET;
          w_load_first = 1'b1;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
        ST_SET: begin
          w_load_cnt = 1'b1;
          if (READ_LAT == 0) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_EMIT;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_EMIT;
          end else begin
            w_dec_cnt = 1'b1;
          end
        end
        ST_EMIT: begin
          if (r_out_valid && i_out_ready) begin
            w_clear_valid = 1'b1;
            if (r_debug_addr == LAST_A) begin
              w_set_done  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_inc_addr  = 1'b1;
              w_state_nxt = ST_SET;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_debug_en   <= 1'b0;
      r_debug_addr <= FIRST_A;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_debug_en <= i_dbg_mode;
      r_done     <= w_set_done;
      if (w_load_first) begin
        r_debug_addr <= FIRST_A;
      end else if (w_inc_addr) begin
        r_debug_addr <= r_debug_addr + ADDR_W'(1);
      end
      if (w_load_cnt) begin
        r_cnt <= CNT_W'(READ_LAT);
      end else if (w_dec_cnt) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= r_debug_addr;
        r_out_data  <= i_debug_data;
      end else if (w_clear_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_debug_en   = r_debug_en;
  assign o_debug_step = (r_state == ST_STEP);
  assign o_debug_addr = r_debug_addr;
  assign o_out_valid  = r_out_valid;
  assign o_out_addr   = r_out_addr;
  assign o_out_data   = r_out_data;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;

endmodule

// File: tb/tb_rv32_debug_scan.sv
module tb_rv32_debug_scan;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned AF = 0;
  localparam int unsigned AL = 127;
  localparam int unsigned RL = 1;
  localparam int NWORDS   = AL - AF + 1;
  localparam int PER_WORD = RL + 3;

  logic          clk = 1'b0;
  logic          rst, dbg_mode, step_req, scan_start, out_ready;
  logic [DW-1:0] debug_data;
  logic          debug_en, debug_step, out_valid, busy, done;
  logic [AW-1:0] debug_addr, out_addr;
  logic [DW-1:0] out_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Core model: debug_data reflects debug_addr RL (=1) cycle later.
  always @(posedge clk) debug_data <= mem[debug_addr];

  rv32_debug_scan #(
    .ADDR_W(AW), .DATA_W(DW), .ADDR_FIRST(AF), .ADDR_LAST(AL), .READ_LAT(RL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_dbg_mode(dbg_mode), .i_step_req(step_req),
    .i_scan_start(scan_start), .i_debug_data(debug_data),
    .o_debug_en(debug_en), .o_debug_step(debug_step), .o_debug_addr(debug_addr),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_addr(out_addr),
    .o_out_data(out_data), .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_debug_en"},   debug_en,   0);
    chk({tag, "_debug_step"}, debug_step, 0);
    chk({tag, "_debug_addr"}, debug_addr, AF);
    chk({tag, "_out_valid"},  out_valid,  0);
    chk({tag, "_out_addr"},   out_addr,   0);
    chk({tag, "_out_data"},   out_data,   0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
  endtask

  // Runs one sweep from IDLE against a scoreboard of the expected beats.
  // Cycle 0 is the cycle in which scan_start is first presented.
  task automatic run_sweep(input bit with_step, input bit rand_ready, input int max_cyc,
                           output int n_beats, output int last_hs, output int n_done,
                           output int done_cyc, output int first_step, output int first_hs);
    logic [AW-1:0] q_a[$];
    logic [DW-1:0] q_d[$];
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    bit stalled;
    for (int a = AF; a <= AL; a++) begin
      q_a.push_back(AW'(a));
      q_d.push_back(mem[a]);
    end
    n_beats = 0; last_hs = -1; n_done = 0; done_cyc = -1;
    first_step = -1; first_hs = -1; stalled = 0; hold_a = '0; hold_d = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        scan_start = 1'b1;
        if (with_step) step_req = 1'b1;
      end else if (busy && !debug_step) begin
        scan_start = 1'b0;
      end
      if (debug_step && first_step < 0) first_step = c;
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, hold_a);
        chk("stall_data", out_data, hold_d);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("beat_addr", out_addr, q_a.pop_front());
          chk("beat_data", out_data, q_d.pop_front());
        end
        n_beats++;
        last_hs = c;
        if (first_hs < 0) first_hs = c;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        hold_a  = out_addr;
        hold_d  = out_data;
      end else begin
        stalled = 0;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    if (done_cyc < 0) chk("sweep_timeout", 0, 1);
    chk("beats_left", q_a.size(), 0);
    step_req = 1'b0; scan_start = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    int n_beats, last_hs, n_done, done_cyc, first_step, first_hs, n_pulse, first_pulse;
    bit seen;
    rst = 1'b1; dbg_mode = 1'b0; step_req = 1'b0; scan_start = 1'b0; out_ready = 1'b1;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a * 4);
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);
    chk("en_before", debug_en, 0);
    dbg_mode = 1'b1;
    @(negedge clk);
    chk("en_follow", debug_en, 1);

    // Single step: step_req held high 10 cycles -> one pulse, one cycle after the edge.
    n_pulse = 0; first_pulse = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) step_req = 1'b1;
      if (debug_step) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = c;
      end
    end
    chk("step_count", n_pulse, 1);
    chk("step_cycle", first_pulse, 1);
    step_req = 1'b0;
`ifdef DEBUG_SCAN_AUTO_RESCAN_EN
    for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
`endif
    repeat (2) @(negedge clk);
    chk("step_idle", busy, 0);

    // Full sweep, ready tied high, data = addr*4.
    run_sweep(0, 0, 2000, n_beats, last_hs, n_done, done_cyc, first_step, first_hs);
    chk("full_beats", n_beats, NWORDS);
    chk("full_done_cnt", n_done, 1);
    chk("full_last_hs", last_hs, NWORDS * PER_WORD);
    chk("full_done_cyc", done_cyc, last_hs + 1);
    chk("full_first_hs", first_hs, PER_WORD);

    // Backpressure with random data.
    for (int a = 0; a < (1 << AW); a++) mem[a] = $urandom;
    run_sweep(0, 1, 5000, n_beats, last_hs, n_done, done_cyc, first_step, first_hs);
    chk("bp_beats", n_beats, NWORDS);
    chk("bp_done_cnt", n_done, 1);
    chk("bp_done_cyc", done_cyc, last_hs + 1);

    // Abort while beat at addr 5 is pending.
    scan_start = 1'b1; seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy && !debug_step) scan_start = 1'b0;
      if (out_valid && out_addr == AW'(5)) begin
        seen = 1;
        break;
      end
    end
    chk("abort_reach5", seen, 1);
    dbg_mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_en", debug_en, 0);
    n_done = done ? 1 : 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_nodone", n_done, 0);
    out_ready = 1'b1; dbg_mode = 1'b1;
    @(negedge clk);
    run_sweep(0, 1, 5000, n_beats, last_hs, n_done, done_cyc, first_step, first_hs);
    chk("restart_beats", n_beats, NWORDS);
    chk("restart_done_cnt", n_done, 1);

    // Step/scan collision: step pulse first, then a complete sweep.
    repeat (2) @(negedge clk);
    run_sweep(1, 0, 2000, n_beats, last_hs, n_done, done_cyc, first_step, first_hs);
    chk("coll_step_cycle", first_step, 1);
    chk("coll_beat_after", first_hs > first_step, 1);
    chk("coll_beats", n_beats, NWORDS);
    chk("coll_done_cnt", n_done, 1);

    // Reset held 3 cycles mid-sweep.
    scan_start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy && !debug_step) scan_start = 1'b0;
    end
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
